// File: rtl/spi_pkg.sv
// Shared types and frame-length helpers for the SPI ALU responder.
// Optional feature macro: SPI_STATUS_EN (adds an 8-bit status byte to the read phase).
package spi_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_COMPUTE,
    ST_TRANSMIT,
    ST_WAIT_NSS
  } resp_state_t;

  localparam int unsigned STATUS_W = 8;

  function automatic int unsigned write_len(input int unsigned cmd_w, input int unsigned data_w);
    return cmd_w + 2 * data_w;
  endfunction

  function automatic int unsigned read_len(input int unsigned data_w);
`ifdef SPI_STATUS_EN
    return data_w + STATUS_W;
`else
    return data_w;
`endif
  endfunction

  localparam int unsigned WRITE_LEN = write_len(8, 32);
  localparam int unsigned READ_LEN  = read_len(32);

endpackage

// File: rtl/spi_alu_responder_if.sv
// SPI link signals between the master and one ALU responder.
interface spi_alu_responder_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;
  logic busy;
  logic frame_done;
  logic frame_abort;

  modport master (
    output sclk, nss, mosi,
    input  miso, busy, frame_done, frame_abort
  );

  modport slave (
    input  sclk, nss, mosi,
    output miso, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizers for sclk/nss/mosi into the system clock domain, with
// single-cycle rise/fall pulses for sclk and nss.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sclk_i,
  input  logic nss_i,
  input  logic mosi_i,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic nss_rise,
  output logic nss_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] nss_sync_q,  nss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   nss_prev_q,  nss_prev_d;

  // Shift each input one stage deeper; remember the last synchronized level.
  always_comb begin
    sclk_sync_d = SYNC_STAGES'({sclk_sync_q, sclk_i});
    nss_sync_d  = SYNC_STAGES'({nss_sync_q, nss_i});
    mosi_sync_d = SYNC_STAGES'({mosi_sync_q, mosi_i});
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    nss_prev_d  = nss_sync_q[SYNC_STAGES-1];
  end

  // nss resets to the "selected" level so that a chip-select already low
  // when reset releases produces no falling edge; a new frame needs nss to
  // go high and then fall again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      nss_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      nss_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      nss_sync_q  <= nss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      nss_prev_q  <= nss_prev_d;
    end
  end

  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
  assign nss_rise  = nss_sync_q[SYNC_STAGES-1] & ~nss_prev_q;
  assign nss_fall  = ~nss_sync_q[SYNC_STAGES-1] & nss_prev_q;
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_alu_responder.sv
// SPI mode-0 responder: receives cmd/opa/opb, computes one ALU result and
// shifts it back on miso within the same nss-low frame.
// Optional feature macro: SPI_STATUS_EN (status byte appended to the result).
module spi_alu_responder
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CMD_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clock,
  input logic                reset,
  spi_alu_responder_if.slave bus
);

  localparam int unsigned WR_W = write_len(CMD_W, DATA_W);
  localparam int unsigned RD_W = read_len(DATA_W);
  // Only opcode + operands are kept; the ignored upper command bits are
  // shifted out of the top of the receive register during the write phase.
  localparam int unsigned RX_W = 3 + 2 * DATA_W;
  localparam int unsigned WC_W = $clog2(WR_W + 1);
  localparam int unsigned RC_W = $clog2(RD_W + 1);
  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned M    = DATA_W - 1;
  localparam logic [WC_W-1:0] WR_LAST = WC_W'(WR_W - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD_W - 1);

  logic sclk_rise, sclk_fall, nss_rise, nss_fall, mosi_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .sclk_i    (bus.sclk),
    .nss_i     (bus.nss),
    .mosi_i    (bus.mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .nss_rise  (nss_rise),
    .nss_fall  (nss_fall),
    .mosi_s    (mosi_s)
  );

  resp_state_t       state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic [RD_W-1:0]   tx_q, tx_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              pend_q, pend_d;
  logic              miso_q, miso_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  alu_op_t           op;
  logic [DATA_W-1:0] opa, opb, result;
  logic [RD_W-1:0]   read_word;

  function automatic logic [DATA_W-1:0] alu_f(input alu_op_t f_op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (f_op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[SH_W-1:0];
      OP_SRL:  r = a >> b[SH_W-1:0];
      OP_SLT:  r[0] = $signed(a) < $signed(b);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op     = alu_op_t'(rx_q[RX_W-1 -: 3]);
  assign opa    = rx_q[2*DATA_W-1 -: DATA_W];
  assign opb    = rx_q[DATA_W-1:0];
  assign result = alu_f(op, opa, opb);

`ifdef SPI_STATUS_EN
  logic [4:0] frames_q, frames_d;
  logic       carry, ovf;

  // Carry/overflow derived from operand and result MSBs; SUB carry is not-borrow.
  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    if (op == OP_ADD) begin
      carry = (opa[M] & opb[M]) | ((opa[M] | opb[M]) & ~result[M]);
      ovf   = (opa[M] == opb[M]) && (result[M] != opa[M]);
    end else if (op == OP_SUB) begin
      carry = (opa[M] & ~opb[M]) | ((opa[M] | ~opb[M]) & ~result[M]);
      ovf   = (opa[M] != opb[M]) && (result[M] != opa[M]);
    end
  end

  assign read_word = {result, (result == '0), carry, ovf, frames_q};
`else
  assign read_word = result;
`endif

  // Frame state machine: next state, shift registers and output pulses.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_q;
    miso_d  = miso_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
`ifdef SPI_STATUS_EN
    frames_d = frames_q;
`endif
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (nss_fall) begin
          state_d = ST_RECEIVE;
          wcnt_d  = '0;
          rx_d    = '0;
        end
      end
      ST_RECEIVE, ST_COMPUTE, ST_TRANSMIT: begin
        if (nss_rise) begin
          // Abort takes priority over any sclk edge in the same cycle.
          state_d = ST_IDLE;
          abort_d = 1'b1;
          miso_d  = 1'b0;
          rx_d    = '0;
          tx_d    = '0;
          pend_d  = 1'b0;
        end else if (state_q == ST_RECEIVE) begin
          if (sclk_rise) begin
            rx_d   = {rx_q[RX_W-2:0], mosi_s};
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WR_LAST) state_d = ST_COMPUTE;
          end
        end else if (state_q == ST_COMPUTE) begin
          tx_d    = read_word;
          miso_d  = read_word[RD_W-1];
          rcnt_d  = '0;
          pend_d  = 1'b0;
          state_d = ST_TRANSMIT;
        end else begin
          // pend_q gates shifting so the fall right after the last write bit is skipped.
          if (sclk_rise) begin
            if (rcnt_q == RD_LAST) begin
              done_d  = 1'b1;
              miso_d  = 1'b0;
              state_d = ST_WAIT_NSS;
`ifdef SPI_STATUS_EN
              frames_d = frames_q + 5'd1;
`endif
            end else begin
              rcnt_d = rcnt_q + 1'b1;
              pend_d = 1'b1;
            end
          end else if (sclk_fall && pend_q) begin
            tx_d   = {tx_q[RD_W-2:0], 1'b0};
            miso_d = tx_q[RD_W-2];
            pend_d = 1'b0;
          end
        end
      end
      ST_WAIT_NSS: begin
        miso_d = 1'b0;
        pend_d = 1'b0;
        if (nss_rise) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef SPI_STATUS_EN
      frames_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      abort_q <= abort_d;
`ifdef SPI_STATUS_EN
      frames_q <= frames_d;
`endif
    end
  end

  assign bus.miso        = miso_q;
  assign bus.busy        = (state_q == ST_RECEIVE) || (state_q == ST_COMPUTE) ||
                           (state_q == ST_TRANSMIT);
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_alu_responder.sv
// Self-checking bench for spi_alu_responder: scoreboard of expected read words.
`timescale 1ns/1ps
module tb_spi_alu_responder;
  import spi_pkg::*;

  localparam int unsigned RD_W = READ_LEN;
  localparam int unsigned WR_W = WRITE_LEN;
  localparam int HALF = 8;  // 16 clocks per sclk period

  logic clock = 1'b0;
  logic reset = 1'b1;

  spi_alu_responder_if bus();

  spi_alu_responder #(.DATA_W(32), .CMD_W(8), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int abort_seen = 0;
  int frames_model = 0;
  logic [RD_W-1:0] sb[$];

  always @(negedge clock) begin
    if (bus.frame_done === 1'b1) done_seen++;
    if (bus.frame_abort === 1'b1) abort_seen++;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a + (~b) + 32'd1;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0}; end
      3'd6: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]}; end
      default: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
    endcase
    return r;
  endfunction

  function automatic logic [RD_W-1:0] model_word(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input int nframes);
    logic [31:0] r;
    r = model_alu(op, a, b);
`ifdef SPI_STATUS_EN
    begin
      logic [32:0] s;
      logic c, v;
      logic [4:0] cnt;
      c = 1'b0; v = 1'b0;
      if (op == 3'd0) begin
        s = {1'b0, a} + {1'b0, b}; c = s[32];
        s = {a[31], a} + {b[31], b}; v = s[32] != s[31];
      end else if (op == 3'd1) begin
        c = (a >= b);
        s = {a[31], a} - {b[31], b}; v = s[32] != s[31];
      end
      cnt = nframes[4:0];
      return {r, (r == 32'd0), c, v, cnt};
    end
`else
    return r;
`endif
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives one frame; stops after wr_bits/rd_bits, optionally adds extra sclk
  // cycles and releases nss.
  task automatic drive_frame(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int wr_bits, input int rd_bits, input int extra,
                             input bit release_nss,
                             output logic [RD_W-1:0] got, output logic extra_miso);
    logic [71:0] w;
    w = {5'b10101, op, a, b};
    got = '0;
    extra_miso = 1'b0;
    bus.nss = 1'b0;
    wait_clks(4);
    for (int i = 0; i < wr_bits; i++) begin
      bus.mosi = w[71-i];
      wait_clks(HALF); bus.sclk = 1'b1;
      wait_clks(HALF); bus.sclk = 1'b0;
    end
    bus.mosi = 1'b0;
    for (int j = 0; j < rd_bits; j++) begin
      wait_clks(HALF); bus.sclk = 1'b1;
      got = {got[RD_W-2:0], bus.miso};
      wait_clks(HALF); bus.sclk = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      wait_clks(HALF); bus.sclk = 1'b1; extra_miso |= bus.miso;
      wait_clks(HALF); bus.sclk = 1'b0; extra_miso |= bus.miso;
    end
    if (release_nss) begin
      wait_clks(HALF); bus.nss = 1'b1;
      wait_clks(HALF);
    end
  endtask

  task automatic full_frame(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int extra, output logic [RD_W-1:0] got,
                            output logic extra_miso);
    sb.push_back(model_word(op, a, b, frames_model));
    drive_frame(op, a, b, WR_W, RD_W, extra, 1'b1, got, extra_miso);
    frames_model++;
  endtask

  task automatic test_reset;
    wait_clks(3);
    #1;
    checks++; if (bus.miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", bus.miso); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.frame_done); end
    checks++; if (bus.frame_abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", bus.frame_abort); end
    wait_clks(1);
    reset = 1'b0;
    wait_clks(6);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_add;
    logic [RD_W-1:0] got, exp;
    logic xm;
    done_seen = 0;
    full_frame(3'd0, 32'd5, 32'd7, 0, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL add_result got=%h exp=%h", got, exp); end
    checks++; if (done_seen != 1) begin failures++; $display("FAIL add_done_count got=%0d exp=1", done_seen); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL add_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_sub;
    logic [RD_W-1:0] got, exp;
    logic xm;
    full_frame(3'd1, 32'd3, 32'd5, 0, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL sub_result got=%h exp=%h", got, exp); end
  endtask

  task automatic test_shift_compare;
    logic [RD_W-1:0] got, exp;
    logic xm;
    full_frame(3'd5, 32'd1, 32'h0000003F, 0, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL sll_result got=%h exp=%h", got, exp); end
    full_frame(3'd7, 32'hFFFFFFFF, 32'd0, 0, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL slt_result got=%h exp=%h", got, exp); end
    full_frame(3'd6, 32'h80000000, 32'h00000024, 0, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL srl_result got=%h exp=%h", got, exp); end
  endtask

  task automatic test_abort;
    logic [RD_W-1:0] got, exp;
    logic xm;
    done_seen = 0; abort_seen = 0;
    drive_frame(3'd0, 32'h12345678, 32'h9ABCDEF0, 40, 0, 0, 1'b1, got, xm);
    checks++; if (abort_seen != 1) begin failures++; $display("FAIL abort_pulse got=%0d exp=1", abort_seen); end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    checks++; if (bus.miso !== 1'b0) begin failures++; $display("FAIL abort_miso got=%b exp=0", bus.miso); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    full_frame(3'd4, 32'hF0F0F0F0, 32'hFFFF0000, 0, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL xor_after_abort got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid_frame;
    logic [RD_W-1:0] got, exp;
    logic xm, busy_any;
    drive_frame(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, WR_W, 10, 0, 1'b0, got, xm);
    checks++; if (got[9:0] !== 10'h3FF) begin failures++; $display("FAIL pre_reset_bits got=%h exp=3ff", got[9:0]); end
    wait_clks(1);
    reset = 1'b1;
    #1;
    checks++; if (bus.miso !== 1'b0) begin failures++; $display("FAIL midreset_miso got=%b exp=0", bus.miso); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    wait_clks(3);
    reset = 1'b0;
    frames_model = 0;
    done_seen = 0;
    busy_any = 1'b0;
    for (int k = 0; k < 80; k++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      wait_clks(HALF); bus.sclk = 1'b1; busy_any |= bus.busy | bus.miso;
      wait_clks(HALF); bus.sclk = 1'b0; busy_any |= bus.busy | bus.miso;
    end
    checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL post_reset_response got=%b exp=0", busy_any); end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL post_reset_done got=%0d exp=0", done_seen); end
    bus.nss = 1'b1;
    wait_clks(HALF);
    full_frame(3'd3, 32'h00FF0000, 32'h0000A5A5, 0, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL or_after_reset got=%h exp=%h", got, exp); end
  endtask

  task automatic test_extra_sclk;
    logic [RD_W-1:0] got, exp;
    logic xm;
    done_seen = 0;
    full_frame(3'd0, 32'h7FFFFFFF, 32'd1, 8, got, xm);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL extra_result got=%h exp=%h", got, exp); end
    checks++; if (xm !== 1'b0) begin failures++; $display("FAIL extra_miso got=%b exp=0", xm); end
    checks++; if (done_seen != 1) begin failures++; $display("FAIL extra_done_count got=%0d exp=1", done_seen); end
  endtask

  task automatic test_back_to_back;
    logic [RD_W-1:0] got, exp;
    logic xm;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int n = 0; n < 6; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      full_frame(op, a, b, 0, got, xm);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_%0d op=%0d a=%h b=%h got=%h exp=%h", n, op, a, b, got, exp);
      end
    end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.nss  = 1'b1;
    bus.mosi = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shift_compare();
    test_abort();
    test_reset_mid_frame();
    test_extra_sclk();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
